// File: rtl/carfield_pkg.sv
// carfield_pkg: mailbox register offsets, STATUS/IRQ bit positions and default depth.
package carfield_pkg;

    localparam int unsigned MboxDepth = 8;

    typedef enum logic [11:0] {
        MBOX_DATA_TX  = 12'h000,
        MBOX_DATA_RX  = 12'h004,
        MBOX_STATUS   = 12'h008,
        MBOX_IRQ_EN   = 12'h00C,
        MBOX_IRQ_STAT = 12'h010,
        MBOX_CTRL     = 12'h014
    } mbox_reg_off_e;

    localparam int unsigned StsRxEmpty = 0;
    localparam int unsigned StsRxFull  = 1;
    localparam int unsigned StsTxEmpty = 2;
    localparam int unsigned StsTxFull  = 3;
    localparam int unsigned StsRxLevel = 8;
    localparam int unsigned StsTxLevel = 16;

    localparam int unsigned IrqRxPush    = 0;
    localparam int unsigned IrqTxNotFull = 1;
    localparam int unsigned IrqErr       = 2;

    function automatic logic mbox_off_mapped(input logic [11:0] off);
        return off inside {MBOX_DATA_TX, MBOX_DATA_RX, MBOX_STATUS,
                           MBOX_IRQ_EN, MBOX_IRQ_STAT, MBOX_CTRL};
    endfunction

endpackage

// File: rtl/carfield_mailbox_fifo.sv
// carfield_mailbox_fifo: flop-array FIFO with push/pop/flush, full/empty/level.
module carfield_mailbox_fifo #(
    parameter int unsigned Depth     = 8,
    parameter int unsigned DataWidth = 32,
    localparam int unsigned PtrW     = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 pop_i,
    input  logic                 flush_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 pushed_o,
    output logic                 popped_o,
    output logic [PtrW:0]        level_o
);

    logic [PtrW:0]        wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] mem_d [Depth];

    // Full/empty come from pre-edge counters, so a same-cycle pop never frees room for a push.
    always_comb begin
        level_o  = wr_cnt_q - rd_cnt_q;
        full_o   = level_o == (PtrW+1)'(Depth);
        empty_o  = level_o == '0;
        pushed_o = push_i && !full_o && !flush_i;
        popped_o = pop_i && !empty_o;
        rdata_o  = mem_q[rd_cnt_q[PtrW-1:0]];
        wr_cnt_d = flush_i ? '0 : wr_cnt_q + (PtrW+1)'(pushed_o);
        rd_cnt_d = flush_i ? '0 : rd_cnt_q + (PtrW+1)'(popped_o);
        mem_d    = mem_q;
        if (pushed_o) mem_d[wr_cnt_q[PtrW-1:0]] = wdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/carfield_mailbox.sv
// carfield_mailbox: bidirectional doorbell mailbox, host port A / security island port B.
// Define CARFIELD_MBOX_ERR_RESP_EN to also flag overflow/underflow on error_o.
module carfield_mailbox
    import carfield_pkg::*;
#(
    parameter int unsigned Depth     = MboxDepth,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    localparam int unsigned PtrW     = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 a_valid_i,
    input  logic                 a_write_i,
    input  logic [AddrWidth-1:0] a_addr_i,
    input  logic [DataWidth-1:0] a_wdata_i,
    output logic                 a_ready_o,
    output logic [DataWidth-1:0] a_rdata_o,
    output logic                 a_error_o,
    input  logic                 b_valid_i,
    input  logic                 b_write_i,
    input  logic [AddrWidth-1:0] b_addr_i,
    input  logic [DataWidth-1:0] b_wdata_i,
    output logic                 b_ready_o,
    output logic [DataWidth-1:0] b_rdata_o,
    output logic                 b_error_o,
    output logic                 irq_a_o,
    output logic                 irq_b_o
);

`ifdef CARFIELD_MBOX_ERR_RESP_EN
    localparam logic ErrResp = 1'b1;
`else
    localparam logic ErrResp = 1'b0;
`endif

    logic                 valid [2];
    logic                 write [2];
    logic [11:0]          off   [2];
    logic [DataWidth-1:0] wdata [2];
    logic [DataWidth-1:0] rdata [2];
    logic                 error [2];
    logic                 irq   [2];

    // Index 0 is port A, 1 is port B; FIFO p is port p's outgoing queue.
    logic                 f_push   [2];
    logic                 f_pop    [2];
    logic                 f_flush  [2];
    logic [DataWidth-1:0] f_rdata  [2];
    logic                 f_full   [2];
    logic                 f_empty  [2];
    logic                 f_pushed [2];
    logic                 f_popped [2];
    logic [PtrW:0]        f_level  [2];
    logic                 unused_addr;

    assign valid[0] = a_valid_i;
    assign valid[1] = b_valid_i;
    assign write[0] = a_write_i;
    assign write[1] = b_write_i;
    assign off[0]   = a_addr_i[11:0];
    assign off[1]   = b_addr_i[11:0];
    assign wdata[0] = a_wdata_i;
    assign wdata[1] = b_wdata_i;
    assign a_ready_o = a_valid_i;
    assign b_ready_o = b_valid_i;
    assign a_rdata_o = rdata[0];
    assign b_rdata_o = rdata[1];
    assign a_error_o = error[0];
    assign b_error_o = error[1];
    assign irq_a_o   = irq[0];
    assign irq_b_o   = irq[1];
    assign unused_addr = ^{a_addr_i[AddrWidth-1:12], b_addr_i[AddrWidth-1:12]};

    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam int Q = 1 - p;
        logic        wr_en, rd_en, push, pop, flush, ovf, udf, irq_q, irq_d;
        logic [2:0]  stat_q, stat_d, en_q, en_d, set, clr;
        logic [31:0] status;
        logic [DataWidth-1:0] rd;

        carfield_mailbox_fifo #(
            .Depth     (Depth),
            .DataWidth (DataWidth)
        ) u_fifo (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .push_i   (f_push[p]),
            .wdata_i  (wdata[p]),
            .pop_i    (f_pop[Q]),
            .flush_i  (f_flush[p]),
            .rdata_o  (f_rdata[p]),
            .full_o   (f_full[p]),
            .empty_o  (f_empty[p]),
            .pushed_o (f_pushed[p]),
            .popped_o (f_popped[p]),
            .level_o  (f_level[p])
        );

        assign f_push[p]  = push;
        assign f_pop[p]   = pop;
        assign f_flush[p] = flush;
        assign rdata[p]   = rd;
        assign irq[p]     = irq_q;

        always_comb begin
            wr_en  = valid[p] && write[p];
            rd_en  = valid[p] && !write[p];
            push   = wr_en && off[p] == MBOX_DATA_TX;
            pop    = rd_en && off[p] == MBOX_DATA_RX;
            flush  = wr_en && off[p] == MBOX_CTRL && wdata[p][0];
            ovf    = push && f_full[p] && !flush;
            udf    = pop && f_empty[Q];
            status = '0;
            status[StsRxEmpty] = f_empty[Q];
            status[StsRxFull]  = f_full[Q];
            status[StsTxEmpty] = f_empty[p];
            status[StsTxFull]  = f_full[p];
            status[StsRxLevel +: 8] = 8'(f_level[Q]);
            status[StsTxLevel +: 8] = 8'(f_level[p]);
            rd = !rd_en                    ? '0 :
                 off[p] == MBOX_DATA_RX    ? (f_empty[Q] ? '0 : f_rdata[Q]) :
                 off[p] == MBOX_STATUS     ? DataWidth'(status) :
                 off[p] == MBOX_IRQ_EN     ? DataWidth'(en_q) :
                 off[p] == MBOX_IRQ_STAT   ? DataWidth'(stat_q) : '0;
            error[p] = valid[p] && (!mbox_off_mapped(off[p]) || (ErrResp && (ovf || udf)));
            set = '0;
            set[IrqRxPush]    = f_pushed[Q];
            set[IrqTxNotFull] = f_full[p] && (f_popped[p] || flush);
            set[IrqErr]       = ovf || udf;
            clr    = (wr_en && off[p] == MBOX_IRQ_STAT) ? wdata[p][2:0] : 3'b0;
            stat_d = set | (stat_q & ~clr);
            en_d   = (wr_en && off[p] == MBOX_IRQ_EN) ? wdata[p][2:0] : en_q;
            irq_d  = |(stat_q & en_q);
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                stat_q <= '0;
                en_q   <= '0;
                irq_q  <= 1'b0;
            end else begin
                stat_q <= stat_d;
                en_q   <= en_d;
                irq_q  <= irq_d;
            end
        end
    end

endmodule

// File: tb/tb_carfield_mailbox.sv
// tb_carfield_mailbox: directed vectors with hand-computed expectations for carfield_mailbox.
module tb_carfield_mailbox;

`ifdef CARFIELD_MBOX_ERR_RESP_EN
    localparam logic [31:0] ExpErr = 32'd1;
`else
    localparam logic [31:0] ExpErr = 32'd0;
`endif

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        a_valid_i = 0, a_write_i = 0, b_valid_i = 0, b_write_i = 0;
    logic [31:0] a_addr_i = 0, a_wdata_i = 0, b_addr_i = 0, b_wdata_i = 0;
    logic [31:0] a_rdata_o, b_rdata_o;
    logic        a_ready_o, b_ready_o, a_error_o, b_error_o, irq_a_o, irq_b_o;

    logic [31:0] a_rd, b_rd, rd;
    logic        a_er, b_er, er, a_rdy;
    int          n_cmp = 0, n_err = 0;

    carfield_mailbox dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_valid_i(a_valid_i), .a_write_i(a_write_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
        .a_ready_o(a_ready_o), .a_rdata_o(a_rdata_o), .a_error_o(a_error_o),
        .b_valid_i(b_valid_i), .b_write_i(b_write_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
        .b_ready_o(b_ready_o), .b_rdata_o(b_rdata_o), .b_error_o(b_error_o),
        .irq_a_o(irq_a_o), .irq_b_o(irq_b_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic av, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                       input logic bv, input logic bw, input logic [31:0] ba, input logic [31:0] bd);
        @(negedge clk_i);
        a_valid_i = av; a_write_i = aw; a_addr_i = aa; a_wdata_i = ad;
        b_valid_i = bv; b_write_i = bw; b_addr_i = ba; b_wdata_i = bd;
        #1;
        a_rd = a_rdata_o; a_er = a_error_o; a_rdy = a_ready_o;
        b_rd = b_rdata_o; b_er = b_error_o;
        @(posedge clk_i);
        #1;
        a_valid_i = 0; b_valid_i = 0;
    endtask

    task automatic acc(input bit p, input logic w, input logic [31:0] ad, input logic [31:0] d);
        if (!p) cyc(1, w, ad, d, 0, 0, 0, 0);
        else    cyc(0, 0, 0, 0, 1, w, ad, d);
        rd = p ? b_rd : a_rd;
        er = p ? b_er : a_er;
    endtask

    initial begin
        #3;
        check("rst_ready", {31'b0, a_ready_o}, 0);
        check("rst_rdata", a_rdata_o, 0);
        check("rst_irqs", {30'b0, irq_a_o, irq_b_o}, 0);
        @(negedge clk_i); @(negedge clk_i);
        rst_i = 0;
        acc(0, 0, 32'h08, 0);
        check("rst_a_status", rd, 32'h5);
        check("ready_eq_valid", {31'b0, a_rdy}, 1);

        // 1: single doorbell A -> B
        acc(1, 1, 32'h0C, 1);
        acc(0, 1, 32'h00, 32'hCAFE_0001);
        acc(1, 0, 32'h08, 0);
        check("t1_b_status", rd, 32'h0000_0104);
        acc(1, 0, 32'h10, 0);
        check("t1_b_irqstat", rd, 1);
        check("t1_irq_b", {31'b0, irq_b_o}, 1);
        check("t1_irq_a", {31'b0, irq_a_o}, 0);
        acc(1, 0, 32'h04, 0);
        check("t1_b_pop", rd, 32'hCAFE_0001);
        check("t1_b_pop_err", {31'b0, er}, 0);
        acc(1, 0, 32'h08, 0);
        check("t1_b_status_empty", rd, 32'h5);
        acc(1, 1, 32'h10, 7);
        acc(1, 1, 32'h0C, 0);

        // 2: overflow and underflow
        for (int i = 0; i < 9; i++) begin
            acc(0, 1, 32'h00, 32'h100 + i);
            if (i == 0) check("t2_push_err", {31'b0, er}, 0);
            if (i == 8) check("t2_ovf_err", {31'b0, er}, ExpErr);
        end
        acc(0, 0, 32'h08, 0);
        check("t2_a_status_full", rd, 32'h0008_0009);
        acc(1, 0, 32'h08, 0);
        check("t2_b_status_full", rd, 32'h0000_0806);
        acc(0, 0, 32'h10, 0);
        check("t2_a_irqstat_ovf", rd, 4);
        for (int i = 0; i < 9; i++) begin
            acc(1, 0, 32'h04, 0);
            check($sformatf("t2_pop%0d", i), rd, (i < 8) ? 32'h100 + i : 32'h0);
            if (i == 8) check("t2_udf_err", {31'b0, er}, ExpErr);
        end
        acc(0, 0, 32'h10, 0);
        check("t2_a_irqstat", rd, 6);
        acc(1, 0, 32'h10, 0);
        check("t2_b_irqstat", rd, 5);
        acc(0, 1, 32'h10, 7);
        acc(1, 1, 32'h10, 7);

        // 3: push + pop on full FIFO
        for (int i = 0; i < 8; i++) acc(0, 1, 32'h00, 32'h200 + i);
        cyc(1, 1, 32'h00, 32'hDEAD, 1, 0, 32'h04, 0);
        check("t3_pop_data", b_rd, 32'h200);
        check("t3_push_err", {31'b0, a_er}, ExpErr);
        acc(0, 0, 32'h08, 0);
        check("t3_a_status", rd, 32'h0007_0001);
        acc(0, 0, 32'h10, 0);
        check("t3_a_irqstat", rd, 6);
        acc(0, 1, 32'h14, 1);
        acc(0, 0, 32'h08, 0);
        check("t3_flush_status", rd, 32'h5);
        acc(0, 1, 32'h10, 7);
        acc(1, 1, 32'h10, 7);

        // 4: flush concurrent with peer pop
        for (int i = 0; i < 3; i++) acc(0, 1, 32'h00, 32'h300 + i);
        cyc(1, 1, 32'h14, 1, 1, 0, 32'h04, 0);
        check("t4_pop_data", b_rd, 32'h300);
        check("t4_pop_err", {31'b0, b_er}, 0);
        acc(0, 0, 32'h08, 0);
        check("t4_a_status", rd, 32'h5);
        acc(1, 0, 32'h10, 0);
        check("t4_b_irqstat", rd, 1);
        acc(0, 1, 32'h10, 7);
        acc(1, 1, 32'h10, 7);

        // 5: set beats W1C in the same cycle
        acc(0, 1, 32'h0C, 1);
        acc(1, 1, 32'h00, 32'h55);
        cyc(1, 1, 32'h10, 1, 1, 1, 32'h00, 32'h66);
        acc(0, 0, 32'h10, 0);
        check("t5_set_wins", rd, 1);
        check("t5_irq_a_on", {31'b0, irq_a_o}, 1);
        acc(0, 1, 32'h10, 1);
        acc(0, 0, 32'h10, 0);
        check("t5_cleared", rd, 0);
        check("t5_irq_a_off", {31'b0, irq_a_o}, 0);

        // 6: unmapped access and reset mid-burst
        acc(0, 0, 32'h40, 0);
        check("t6_unmapped_err", {31'b0, er}, 1);
        check("t6_unmapped_rdata", rd, 0);
        acc(0, 1, 32'h44, 32'hFFFF_FFFF);
        check("t6_unmapped_werr", {31'b0, er}, 1);
        acc(0, 0, 32'h10, 0);
        check("t6_no_side_effect", rd, 0);
        acc(1, 1, 32'h00, 32'h77);
        acc(0, 0, 32'h08, 0);
        check("t6_a_rx_level", rd, 32'h0000_0304);
        check("t6_irq_a_pre", {31'b0, irq_a_o}, 1);
        @(negedge clk_i);
        a_valid_i = 1; a_write_i = 1; a_addr_i = 0; a_wdata_i = 32'h88;
        #2 rst_i = 1;
        #1 check("t6_rst_irqs", {30'b0, irq_a_o, irq_b_o}, 0);
        @(posedge clk_i);
        #1 a_valid_i = 0;
        @(negedge clk_i);
        rst_i = 0;
        acc(0, 0, 32'h08, 0);
        check("t6_a_status", rd, 32'h5);
        acc(1, 0, 32'h08, 0);
        check("t6_b_status", rd, 32'h5);
        acc(0, 0, 32'h0C, 0);
        check("t6_a_irqen", rd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
